retire_trace: RTL and testbench

Parametrised retired-instruction trace buffer at the writeback end of the 5-stage core. It captures one record {pc, inst, rd_num, rd value} per retired instruction into a DEPTH-entry circular store, with optional PC trigger, pre-trigger history (wrap mode) and post-trigger count. Records are read out oldest-first over a valid/ready port once capture has stopped, giving a synthesizable replacement for simulation-only per-stage dumps.

---
 rtl/retire_trace.sv | 151 +++++++++++++++
 tb/tb_retire_trace.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace.sv
// Retired-instruction trace buffer: circular capture of {pc, inst, rd_num, rd}
// with optional PC trigger, pre-trigger history and post-trigger count.
module retire_trace #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   input  logic [XLEN-1:0] i_pc,
   input  logic [31:0]     i_inst,
   input  logic [4:0]      i_rd_num,
   input  logic [XLEN-1:0] i_rd,
   input  logic            i_arm,
   input  logic            i_stop,
   input  logic            i_wrap,
   input  logic            i_trig_en,
   input  logic [XLEN-1:0] i_trig_pc,
   input  logic [CW-1:0]   i_post_cnt,
   input  logic            i_tr_ready,
   output logic            tr_valid,
   output logic [XLEN-1:0] tr_pc,
   output logic [31:0]     tr_inst,
   output logic [4:0]      tr_rd_num,
   output logic [XLEN-1:0] tr_rd,
   output logic [CW-1:0]   count,
   output logic [1:0]      state,
   output logic [15:0]     overwr
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 2*XLEN + 37;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic [RW-1:0]   mem [DEPTH];
   logic [RW-1:0]   head;
   logic [AW-1:0]   wp, rp;
   logic            wrap_q, trig_en_q;
   logic [XLEN-1:0] trig_pc_q;
   logic [CW-1:0]   post_q, post_left, post_nx, post_clamp;
   logic [1:0]      state_nx;
   logic            match, store, full, pop;

   always_comb begin
      match    = i_valid && (i_pc == trig_pc_q);
      full     = (count == FULL);
      store    = 1'b0;
      state_nx = state;
      post_nx  = post_left;
      case (state)
         ARMED: begin
            if (match) begin
               store = 1'b1;
               // in wrap mode the trigger record itself consumes one post slot
               if (wrap_q) begin
                  post_nx  = post_q - 1'b1;
                  state_nx = (post_q == ONE) ? DONE : CAPTURE;
               end else begin
                  state_nx = (count == FULL_M1) ? DONE : CAPTURE;
               end
            end else if (i_valid && wrap_q) begin
               store = 1'b1;
            end
         end
         CAPTURE: begin
            if (i_valid) begin
               store = 1'b1;
               if (!wrap_q) begin
                  if (count == FULL_M1) state_nx = DONE;
               end else if (trig_en_q) begin
                  post_nx = post_left - 1'b1;
                  if (post_left == ONE) state_nx = DONE;
               end
            end
         end
         default: ;
      endcase
      if (i_stop && (state == ARMED || state == CAPTURE)) state_nx = DONE;
      if (i_arm) store = 1'b0;
   end

   always_comb begin
      post_clamp = i_post_cnt;
      if (i_post_cnt == '0)       post_clamp = ONE;
      else if (i_post_cnt > FULL) post_clamp = FULL;
   end

   assign tr_valid  = (count != '0) && (state == IDLE || state == DONE);
   assign pop       = tr_valid && i_tr_ready;
   assign head      = tr_valid ? mem[rp] : '0;
   assign tr_pc     = head[RW-1 -: XLEN];
   assign tr_inst   = head[XLEN+36 -: 32];
   assign tr_rd_num = head[XLEN+4 -: 5];
   assign tr_rd     = head[XLEN-1:0];

   always_ff @(posedge i_clk) begin
      if (store) mem[wp] <= {i_pc, i_inst, i_rd_num, i_rd};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         overwr    <= '0;
         wrap_q    <= 1'b0;
         trig_en_q <= 1'b0;
         trig_pc_q <= '0;
         post_q    <= ONE;
         post_left <= '0;
      end else if (i_arm) begin
         state     <= i_trig_en ? ARMED : CAPTURE;
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         overwr    <= '0;
         wrap_q    <= i_wrap;
         trig_en_q <= i_trig_en;
         trig_pc_q <= i_trig_pc;
         post_q    <= post_clamp;
         post_left <= '0;
      end else begin
         state     <= state_nx;
         post_left <= post_nx;
         if (store) begin
            wp <= wp + 1'b1;
            // full only occurs in wrap mode: drop the oldest entry
            if (full) begin
               rp <= rp + 1'b1;
               if (overwr != '1) overwr <= overwr + 1'b1;
            end else begin
               count <= count + 1'b1;
            end
         end else if (pop) begin
            rp    <= rp + 1'b1;
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_retire_trace.sv
// Bench for retire_trace: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized episodes.
module tb_retire_trace;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid, arm, stop, wrap, trig_en, ready;
   logic [XLEN-1:0] pc, rd, trig_pc;
   logic [31:0]     inst;
   logic [4:0]      rd_num;
   logic [CW-1:0]   post_cnt;
   logic            tr_valid;
   logic [XLEN-1:0] tr_pc, tr_rd;
   logic [31:0]     tr_inst;
   logic [4:0]      tr_rd_num;
   logic [CW-1:0]   count;
   logic [1:0]      state;
   logic [15:0]     overwr;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_on = 1'b0;

   always #5 clk = ~clk;

   retire_trace #(.DEPTH(DEPTH), .XLEN(XLEN), .CW(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_inst(inst),
      .i_rd_num(rd_num), .i_rd(rd), .i_arm(arm), .i_stop(stop), .i_wrap(wrap),
      .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_post_cnt(post_cnt),
      .i_tr_ready(ready), .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_inst(tr_inst),
      .tr_rd_num(tr_rd_num), .tr_rd(tr_rd), .count(count), .state(state),
      .overwr(overwr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rdn;
      logic [31:0] rd;
   } rec_t;

   rec_t        q[$];
   int          m_state = 0;
   int          m_after = 0;
   int          m_need  = 1;
   logic        m_wrap = 1'b0, m_trig = 1'b0;
   logic [31:0] m_tpc = '0;
   int unsigned m_ov = 0;
   logic        m_hit;
   rec_t        m_rec;

   task automatic m_store();
      q.push_back(m_rec);
      if (q.size() > DEPTH) begin
         void'(q.pop_front());
         if (m_ov != 32'hFFFF) m_ov++;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_state = 0;
         m_ov    = 0;
      end else if (arm) begin
         q.delete();
         m_ov    = 0;
         m_wrap  = wrap;
         m_trig  = trig_en;
         m_tpc   = trig_pc;
         m_need  = (post_cnt == 0) ? 1 : (int'(post_cnt) > DEPTH ? DEPTH : int'(post_cnt));
         m_after = 0;
         m_state = trig_en ? 1 : 2;
      end else begin
         m_hit = valid && (pc == m_tpc);
         m_rec = '{pc: pc, inst: inst, rdn: rd_num, rd: rd};
         case (m_state)
            0, 3: if (q.size() != 0 && ready) void'(q.pop_front());
            1: if (valid && (m_wrap || m_hit)) begin
                  m_store();
                  if (m_hit) begin
                     m_after = 1;
                     m_state = 2;
                  end
               end
            default: if (valid) begin
                  m_store();
                  m_after++;
               end
         endcase
         if (m_state == 2) begin
            if (!m_wrap && q.size() == DEPTH) m_state = 3;
            if (m_wrap && m_trig && m_after >= m_need) m_state = 3;
         end
         if (stop && (m_state == 1 || m_state == 2)) m_state = 3;
      end
   end

   logic m_tv;
   rec_t m_head;
   always @(negedge clk) begin
      if (chk_on) begin
         m_tv   = (q.size() != 0) && (m_state == 0 || m_state == 3);
         m_head = m_tv ? q[0] : '{pc: '0, inst: '0, rdn: '0, rd: '0};
         check("state", state, m_state);
         check("count", count, q.size());
         check("overwr", overwr, m_ov);
         check("tr_valid", tr_valid, m_tv);
         check("tr_pc", tr_pc, m_head.pc);
         check("tr_inst", tr_inst, m_head.inst);
         check("tr_rd_num", tr_rd_num, m_head.rdn);
         check("tr_rd", tr_rd, m_head.rd);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] inst_of(input logic [31:0] p);
      return p * 32'd7 + 32'h13;
   endfunction
   function automatic logic [31:0] rd_of(input logic [31:0] p);
      return ~p ^ 32'h5A5A_0000;
   endfunction
   function automatic logic [4:0] rdn_of(input logic [31:0] p);
      return p[6:2] ^ 5'h11;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ret(input logic [31:0] p);
      valid  = 1'b1;
      pc     = p;
      inst   = inst_of(p);
      rd     = rd_of(p);
      rd_num = rdn_of(p);
   endtask

   task automatic do_arm(input logic w, input logic t, input logic [31:0] tp, input logic [CW-1:0] pcnt);
      valid = 1'b0; arm = 1'b1; wrap = w; trig_en = t; trig_pc = tp; post_cnt = pcnt;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid = 0; arm = 0; stop = 0; wrap = 0; trig_en = 0; ready = 0;
      pc = '0; rd = '0; inst = '0; rd_num = '0; trig_pc = '0; post_cnt = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk_on = 1'b1;
      tick();
      check("reset_state", state, 0);
      check("reset_tv", tr_valid, 0);

      // async reset in the middle of capture
      do_arm(0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin set_ret(32'h100 + 4*k); tick(); end
      valid = 0;
      check("pre_rst_count", count, 3);
      check("pre_rst_state", state, 2);
      rst = 1'b1;
      #1;
      check("rst_state", state, 0);
      check("rst_count", count, 0);
      check("rst_tv", tr_valid, 0);
      check("rst_overwr", overwr, 0);
      check("rst_tr_pc", tr_pc, 0);
      tick();
      rst = 1'b0;
      tick();

      // stop-when-full, no trigger
      do_arm(0, 0, 0, 0);
      check("nw_state_cap", state, 2);
      for (int k = 0; k < 5; k++) begin
         set_ret(4*k);
         tick();
         if (k == 3) begin
            check("nw_done", state, 3);
            check("nw_count", count, 4);
         end
      end
      valid = 0;
      check("nw_count_after", count, 4);
      ready = 1;
      for (int k = 0; k < 4; k++) begin check("nw_pop_pc", tr_pc, 4*k); tick(); end
      ready = 0;
      check("nw_empty_count", count, 0);
      check("nw_empty_tv", tr_valid, 0);
      check("nw_stays_done", state, 3);

      // wrap + trigger with post count
      do_arm(1, 1, 32'h20, 2);
      check("wt_armed", state, 1);
      for (int k = 0; k < 7; k++) begin
         set_ret(32'h10 + 4*k);
         tick();
         if (k == 5) check("wt_done", state, 3);
      end
      valid = 0;
      check("wt_count", count, 4);
      check("wt_overwr", overwr, 2);
      ready = 1;
      for (int k = 0; k < 4; k++) begin check("wt_pop_pc", tr_pc, 32'h18 + 4*k); tick(); end
      ready = 0;

      // no-wrap trigger: pre-trigger retirements discarded
      do_arm(0, 1, 32'h8, 0);
      for (int k = 0; k < 6; k++) begin
         set_ret(4*k);
         tick();
         if (k == 1) check("nt_discard", count, 0);
      end
      valid = 0;
      check("nt_done", state, 3);
      check("nt_count", count, 4);
      ready = 1;
      for (int k = 0; k < 4; k++) begin
         check("nt_pc", tr_pc, 8 + 4*k);
         check("nt_inst", tr_inst, inst_of(8 + 4*k));
         check("nt_rdn", tr_rd_num, rdn_of(8 + 4*k));
         check("nt_rd", tr_rd, rd_of(8 + 4*k));
         tick();
      end
      ready = 0;

      // continuous wrap, stop with a record in the same cycle
      do_arm(1, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin set_ret(4*k); tick(); end
      set_ret(28);
      stop = 1;
      tick();
      stop = 0; valid = 0;
      check("ws_done", state, 3);
      check("ws_count", count, 4);
      check("ws_overwr", overwr, 3);
      ready = 1;
      for (int k = 4; k <= 7; k++) begin check("ws_pop_pc", tr_pc, 4*k); tick(); end
      ready = 0;

      // arm during readout wins over pop
      do_arm(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin set_ret(32'h40 + 4*k); tick(); end
      valid = 0;
      ready = 1;
      tick();
      check("ar_count_popped", count, 3);
      arm = 1; wrap = 0; trig_en = 0;
      tick();
      arm = 0; ready = 0;
      check("ar_count", count, 0);
      check("ar_state", state, 2);
      check("ar_tv", tr_valid, 0);

      // randomized episodes against the model
      for (int ep = 0; ep < 40; ep++) begin
         do_arm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)) * 4, CW'($urandom_range(0, 7)));
         for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
            valid  = ($urandom_range(0, 2) != 0);
            set_ret(32'($urandom_range(0, 15)) * 4);
            valid  = ($urandom_range(0, 2) != 0);
            stop   = ($urandom_range(0, 19) == 0);
            ready  = 1'($urandom_range(0, 1));
            tick();
         end
         valid = 0; stop = 1;
         tick();
         stop = 0;
         for (int c = 0; c < int'($urandom_range(2, 12)); c++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      ready = 0;
      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
